// File: rtl/c1541_sd_xfer.sv
// c1541_sd_xfer: moves a multi-block request from the 1541 track stage to the
// host one 512-byte block at a time, and steers host bytes into the track
// buffer at {block index, byte offset} while a read is in progress.
module c1541_sd_xfer #(
    parameter int BLK_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // track-stage request side
    input  logic [31:0]           sd_lba,
    input  logic [5:0]            sd_blk_cnt,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    // host block interface
    output logic [31:0]           host_lba,
    output logic                  host_rd,
    output logic                  host_wr,
    input  logic                  host_ack,
    input  logic [8:0]            host_buf_addr,
    input  logic [7:0]            host_buf_dout,
    input  logic                  host_buf_wr,
    output logic [7:0]            host_buf_din,
    // track-buffer RAM port
    output logic [BLK_BITS+8:0]   buf_addr,
    output logic                  buf_we,
    output logic [7:0]            buf_dout,
    input  logic [7:0]            buf_din
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        NEXT,
        DONE
    } state_t;

    localparam logic [31:0] MAX_BLK = (32'd1 << BLK_BITS) - 32'd1;

    state_t                state_q,    state_d;
    logic [31:0]           lba_q,      lba_d;
    logic [BLK_BITS-1:0]   cnt_q,      cnt_d;
    logic [BLK_BITS-1:0]   blk_idx_q,  blk_idx_d;
    logic                  dir_rd_q,   dir_rd_d;
    logic                  sd_ack_q,   sd_ack_d;
    logic                  host_rd_q,  host_rd_d;
    logic                  host_wr_q,  host_wr_d;
    logic [31:0]           host_lba_q, host_lba_d;

    // The 6-bit request count can exceed what the buffer holds; saturate it to
    // the last block index so the transfer never wraps onto block 0.
    function automatic logic [BLK_BITS-1:0] clamp_cnt(input logic [5:0] cnt);
        logic [31:0] c32;
        c32 = {26'd0, cnt};
        if (c32 > MAX_BLK) begin
            c32 = MAX_BLK;
        end
        return c32[BLK_BITS-1:0];
    endfunction

    // State and latched-request registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lba_q      <= '0;
            cnt_q      <= '0;
            blk_idx_q  <= '0;
            dir_rd_q   <= 1'b0;
            sd_ack_q   <= 1'b0;
            host_rd_q  <= 1'b0;
            host_wr_q  <= 1'b0;
            host_lba_q <= '0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            cnt_q      <= cnt_d;
            blk_idx_q  <= blk_idx_d;
            dir_rd_q   <= dir_rd_d;
            sd_ack_q   <= sd_ack_d;
            host_rd_q  <= host_rd_d;
            host_wr_q  <= host_wr_d;
            host_lba_q <= host_lba_d;
        end
    end

    // Next-state logic: one host request/ack handshake per block.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        cnt_d      = cnt_q;
        blk_idx_d  = blk_idx_q;
        dir_rd_d   = dir_rd_q;
        sd_ack_d   = sd_ack_q;
        host_rd_d  = host_rd_q;
        host_wr_d  = host_wr_q;
        host_lba_d = host_lba_q;

        unique case (state_q)
            IDLE: begin
                // Requests are only looked at here, so nothing is queued while
                // busy; a read wins when both levels are high.
                if (sd_rd || sd_wr) begin
                    lba_d      = sd_lba;
                    cnt_d      = clamp_cnt(sd_blk_cnt);
                    dir_rd_d   = sd_rd;
                    blk_idx_d  = '0;
                    sd_ack_d   = 1'b1;
                    host_lba_d = sd_lba;
                    host_rd_d  = sd_rd;
                    host_wr_d  = ~sd_rd;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (host_ack) begin
                    host_rd_d = 1'b0;
                    host_wr_d = 1'b0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (!host_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (blk_idx_q == cnt_q) begin
                    // sd_ack drops on entry to DONE so the track stage sees
                    // completion one cycle after the last host_ack fall.
                    sd_ack_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    blk_idx_d  = blk_idx_q + 1'b1;
                    host_lba_d = lba_q + 32'(blk_idx_q) + 32'd1;
                    host_rd_d  = dir_rd_q;
                    host_wr_d  = ~dir_rd_q;
                    state_d    = REQ;
                end
            end
            DONE: begin
                sd_ack_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sd_ack       = sd_ack_q;
    assign host_rd      = host_rd_q;
    assign host_wr      = host_wr_q;
    assign host_lba     = host_lba_q;

    // Buffer port: host bytes land only during the data phase of a read.
    assign buf_addr     = {blk_idx_q, host_buf_addr};
    assign buf_dout     = host_buf_dout;
    assign buf_we       = host_buf_wr && (state_q == XFER) && dir_rd_q;
    assign host_buf_din = buf_din;

endmodule

// File: tb/tb_c1541_sd_xfer.sv
// Bench for c1541_sd_xfer: a track-stage + host model drives transfers and
// compares every host request and every buffer write against a block-level
// model (block k of a request at lba L is lba L+k, bytes land at k*512+off).
module tb_c1541_sd_xfer;

    localparam int BB   = 5;
    localparam int MAXB = 1 << BB;
    localparam int AW   = BB + 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   sd_lba;
    logic [5:0]    sd_blk_cnt;
    logic          sd_rd, sd_wr, sd_ack;
    logic [31:0]   host_lba;
    logic          host_rd, host_wr, host_ack;
    logic [8:0]    host_buf_addr;
    logic [7:0]    host_buf_dout;
    logic          host_buf_wr;
    logic [7:0]    host_buf_din;
    logic [AW-1:0] buf_addr;
    logic          buf_we;
    logic [7:0]    buf_dout, buf_din;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_rises = 0;
    logic [AW+7:0] wlog[$];

    c1541_sd_xfer #(.BLK_BITS(BB)) dut (
        .clk(clk), .reset_n(reset_n),
        .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr), .host_ack(host_ack),
        .host_buf_addr(host_buf_addr), .host_buf_dout(host_buf_dout), .host_buf_wr(host_buf_wr),
        .host_buf_din(host_buf_din),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_dout(buf_dout), .buf_din(buf_din)
    );

    always #5 clk = ~clk;

    // RAM-side observer: every write the buffer would actually take.
    always @(posedge clk) if (buf_we === 1'b1) wlog.push_back({buf_addr, buf_dout});

    always @(posedge sd_ack) ack_rises++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transfer as the track stage and host would run it, with
    // the expected outcome derived from the request alone.
    task automatic do_transfer(input logic [31:0] lba, input logic [5:0] cnt, input logic rd,
                               input logic wr, input int nb, input bit poke, input int abort_at);
        bit            is_read;
        int            exp_n, wstart, rises0, guard, lat, nblk, bad;
        bit            done, aborted;
        logic [AW+7:0] exp_w[$];
        logic [31:0]   got_lba[$];
        logic          got_rd[$];
        logic          got_wr[$];
        logic [31:0]   el;
        is_read = rd;
        exp_n   = (int'(cnt) > MAXB - 1) ? MAXB : int'(cnt) + 1;
        wstart  = wlog.size();
        rises0  = ack_rises;
        nblk    = 0;
        done    = 0;
        aborted = 0;

        @(negedge clk);
        sd_lba = lba; sd_blk_cnt = cnt; sd_rd = rd; sd_wr = wr;
        lat = 0;
        do begin @(negedge clk); lat++; end while (sd_ack !== 1'b1 && lat < 10);
        n_checks++;
        if (lat !== 1) $display("FAIL ack_latency: got %0d cycles, want 1", lat);
        else n_pass++;
        // Track stage drops its request on sd_ack; scramble the buses to show they were latched.
        sd_rd = 0; sd_wr = 0; sd_lba = $urandom; sd_blk_cnt = 6'($urandom);

        while (!done) begin
            guard = 0;
            while (host_rd !== 1'b1 && host_wr !== 1'b1 && guard < 20) begin
                @(negedge clk); guard++;
            end
            if (guard >= 20) begin
                n_checks++;
                $display("FAIL host_req_timeout: block %0d never requested", nblk);
                break;
            end
            got_lba.push_back(host_lba); got_rd.push_back(host_rd); got_wr.push_back(host_wr);
            // Host is slow to answer; stray buffer strobes here must not land.
            repeat ($urandom_range(0, 2)) begin
                host_buf_wr = 1'($urandom); host_buf_dout = 8'($urandom); host_buf_addr = 9'($urandom);
                @(negedge clk);
                n_checks++;
                if ((host_rd | host_wr) !== 1'b1) $display("FAIL req_hold: rd=%b wr=%b, want held", host_rd, host_wr);
                else n_pass++;
            end
            host_buf_wr = 0; host_ack = 1;
            @(negedge clk);
            n_checks++;
            if ({host_rd, host_wr} !== 2'b00) $display("FAIL req_clear: rd/wr=%b, want 00", {host_rd, host_wr});
            else n_pass++;
            if (poke && nblk == 0) begin
                sd_wr = 1; @(negedge clk); sd_wr = 0;
            end
            for (int j = 0; j < nb; j++) begin
                logic [8:0]    off;
                logic [7:0]    d;
                logic [AW-1:0] ea;
                off = (nb == 512) ? 9'(j) : ((j == 0) ? 9'd5 : 9'($urandom));
                d   = 8'($urandom);
                ea  = AW'(nblk * 512 + int'(off));
                host_buf_addr = off; host_buf_dout = d; host_buf_wr = 1;
                if (j == 0) begin
                    #1;
                    n_checks++;
                    if (buf_addr !== ea) $display("FAIL buf_addr: got 0x%0h, want 0x%0h", buf_addr, ea);
                    else n_pass++;
                end
                if (abort_at == nblk) begin
                    n_checks++;
                    if (buf_we !== 1'b1) $display("FAIL pre_abort_we: got %b, want 1", buf_we);
                    else n_pass++;
                    #2 reset_n = 0;
                    #1;
                    n_checks++;
                    if ({sd_ack, host_rd, host_wr, buf_we} !== 4'b0000 || host_lba !== 32'd0 ||
                        buf_addr !== {{BB{1'b0}}, off})
                        $display("FAIL abort_state: ack/rd/wr/we=%b lba=0x%0h addr=0x%0h, want 0000 0 0x%0h",
                                 {sd_ack, host_rd, host_wr, buf_we}, host_lba, buf_addr, off);
                    else n_pass++;
                    aborted = 1;
                    break;
                end
                if (is_read) exp_w.push_back({ea, d});
                @(negedge clk);
            end
            if (aborted) break;
            host_buf_wr = 0; host_ack = 0;
            lat = 0;
            do begin @(negedge clk); lat++; end
            while (sd_ack === 1'b1 && host_rd !== 1'b1 && host_wr !== 1'b1 && lat < 10);
            nblk++;
            n_checks++;
            if (lat !== 2) $display("FAIL block_end_latency: got %0d cycles, want 2", lat);
            else n_pass++;
            if (sd_ack !== 1'b1) done = 1;
        end
        if (aborted) return;

        n_checks++;
        if (nblk !== exp_n) $display("FAIL block_count: got %0d, want %0d", nblk, exp_n);
        else n_pass++;

        bad = 0;
        for (int k = 0; k < got_lba.size(); k++) begin
            el = lba + 32'(k);
            if (got_lba[k] !== el && bad == 0) begin
                $display("FAIL host_lba: block %0d got 0x%08h, want 0x%08h", k, got_lba[k], el);
                bad = 1;
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;

        bad = 0;
        for (int k = 0; k < got_rd.size(); k++) begin
            if ((got_rd[k] !== is_read || got_wr[k] !== !is_read) && bad == 0) begin
                $display("FAIL host_dir: block %0d got rd=%b wr=%b, want rd=%b", k, got_rd[k], got_wr[k], is_read);
                bad = 1;
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;

        bad = 0;
        if (wlog.size() - wstart != exp_w.size()) begin
            $display("FAIL buf_write_count: got %0d, want %0d", wlog.size() - wstart, exp_w.size());
            bad = 1;
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                if (wlog[wstart + k] !== exp_w[k] && bad == 0) begin
                    $display("FAIL buf_write: #%0d got 0x%0h, want 0x%0h", k, wlog[wstart + k], exp_w[k]);
                    bad = 1;
                end
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;

        repeat (3) @(negedge clk);
        n_checks++;
        if (ack_rises - rises0 !== 1 || sd_ack !== 1'b0)
            $display("FAIL ack_pulses: got %0d rises (ack=%b), want 1 (ack=0)", ack_rises - rises0, sd_ack);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        sd_lba = 32'h0; sd_blk_cnt = 6'd0; sd_rd = 0; sd_wr = 0;
        host_ack = 0; host_buf_addr = 9'h1A5; host_buf_dout = 8'h00; host_buf_wr = 1; buf_din = 8'h00;
        reset_n = 0;
        #1;
        n_checks++;
        if ({sd_ack, host_rd, host_wr, buf_we} !== 4'b0000 || host_lba !== 32'd0 || buf_addr !== AW'(9'h1A5))
            $display("FAIL reset_state: ack/rd/wr/we=%b lba=0x%0h addr=0x%0h, want 0000 0 0x1a5",
                     {sd_ack, host_rd, host_wr, buf_we}, host_lba, buf_addr);
        else n_pass++;
        repeat (3) @(negedge clk);
        v = 8'($urandom); buf_din = v; host_buf_dout = ~v;
        #1;
        n_checks++;
        if (host_buf_din !== v || buf_dout !== ~v)
            $display("FAIL passthrough: din=0x%0h dout=0x%0h, want 0x%0h 0x%0h", host_buf_din, buf_dout, v, ~v);
        else n_pass++;
        host_buf_wr = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_single_read();
        do_transfer(32'h100, 6'd0, 1'b1, 1'b0, 512, 1'b0, -1);
    endtask

    task automatic test_multi_read();
        do_transfer(32'h100, 6'h1F, 1'b1, 1'b0, 2, 1'b0, -1);
    endtask

    task automatic test_write();
        int w0;
        w0 = wlog.size();
        do_transfer(32'd357, 6'd18, 1'b0, 1'b1, 3, 1'b0, -1);
        n_checks++;
        if (wlog.size() !== w0) $display("FAIL write_no_we: got %0d buffer writes, want 0", wlog.size() - w0);
        else n_pass++;
    endtask

    task automatic test_both_and_poke();
        do_transfer(32'h2000, 6'd2, 1'b1, 1'b1, 2, 1'b1, -1);
    endtask

    task automatic test_wrap();
        do_transfer(32'hFFFF_FFFF, 6'd1, 1'b0, 1'b1, 1, 1'b0, -1);
    endtask

    task automatic test_clamp();
        do_transfer(32'h55, 6'd63, 1'b1, 1'b0, 1, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        int w0;
        do_transfer(32'h40, 6'd3, 1'b1, 1'b0, 1, 1'b0, 2);
        w0 = wlog.size();
        repeat (3) @(negedge clk);
        n_checks++;
        if (wlog.size() !== w0 || sd_ack !== 1'b0)
            $display("FAIL abort_no_write: got %0d writes ack=%b, want 0 writes ack=0", wlog.size() - w0, sd_ack);
        else n_pass++;
        host_ack = 0; host_buf_wr = 0; host_buf_addr = 9'h033;
        reset_n = 1;
        sd_lba = 32'h900; sd_blk_cnt = 6'd0; sd_rd = 1;
        @(negedge clk);
        n_checks++;
        if (sd_ack !== 1'b1 || host_rd !== 1'b1 || host_lba !== 32'h900 || buf_addr !== AW'(9'h033))
            $display("FAIL restart: ack=%b rd=%b lba=0x%0h addr=0x%0h, want 1 1 0x900 0x33",
                     sd_ack, host_rd, host_lba, buf_addr);
        else n_pass++;
        sd_rd = 0; host_ack = 1;
        @(negedge clk);
        host_ack = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sd_ack !== 1'b0) $display("FAIL restart_done: ack=%b, want 0", sd_ack);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] lba;
        logic [5:0]  cnt;
        logic        rd, wr;
        logic [7:0]  v;
        for (int t = 0; t < 6; t++) begin
            lba = $urandom;
            cnt = (t == 0) ? 6'd40 : 6'($urandom);
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            if (!rd && !wr) wr = 1;
            do_transfer(lba, cnt, rd, wr, $urandom_range(0, 4), 1'($urandom), -1);
            v = 8'($urandom); buf_din = v;
            #1;
            n_checks++;
            if (host_buf_din !== v) $display("FAIL din_passthrough: got 0x%0h, want 0x%0h", host_buf_din, v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_read();
        test_write();
        test_both_and_poke();
        test_wrap();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
